i2c_slave_responder: RTL and testbench

//  Synthesizable I2C target (slave) answering one 7-bit device address; the bus-side counterpart of the

---
 rtl/i2c_slave_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_i2c_slave_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: 7-bit-address I2C target on an oversampled bus.
// Open-drain SDA, write bytes out on a valid pulse, read bytes fetched on request.
module i2c_slave_responder #(
  parameter logic [6:0]  I2C_DEVICE_ADDR = 7'h22,
  parameter int unsigned I2C_DATA_WIDTH  = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_o,
  output logic                      busy_o,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      wr_valid_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i
);
  localparam int unsigned DW = I2C_DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA,
    WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  state_e          state_q, state_d;
  logic            scl_s1_q, scl_s1_d;
  logic            scl_s2_q, scl_s2_d;
  logic            scl_h_q, scl_h_d;
  logic            sda_s1_q, sda_s1_d;
  logic            sda_s2_q, sda_s2_d;
  logic            sda_h_q, sda_h_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic            rw_q, rw_d;
  logic            drv_q, drv_d;
  logic            busy_q, busy_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic            wr_valid_q, wr_valid_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            rd_req_q, rd_req_d;
  logic            ld_q, ld_d;
  logic            acked_q, acked_d;

  logic scl_rise, scl_fall, scl_hi;
  logic start_c, stop_c;

  assign scl_rise = scl_s2_q & ~scl_h_q;
  assign scl_fall = ~scl_s2_q & scl_h_q;
  assign scl_hi   = scl_s2_q & scl_h_q;
  assign start_c  = scl_hi & sda_h_q & ~sda_s2_q;
  assign stop_c   = scl_hi & ~sda_h_q & sda_s2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_h_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_h_q    <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      drv_q      <= 1'b1;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      ld_q       <= 1'b0;
      acked_q    <= 1'b0;
    end else begin
      scl_s1_q   <= scl_s1_d;
      scl_s2_q   <= scl_s2_d;
      scl_h_q    <= scl_h_d;
      sda_s1_q   <= sda_s1_d;
      sda_s2_q   <= sda_s2_d;
      sda_h_q    <= sda_h_d;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      drv_q      <= drv_d;
      busy_q     <= busy_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      ld_q       <= ld_d;
      acked_q    <= acked_d;
    end
  end

  always_comb begin
    scl_s1_d   = scl_i;
    scl_s2_d   = scl_s1_q;
    scl_h_d    = scl_s2_q;
    sda_s1_d   = sda_i;
    sda_s2_d   = sda_s1_q;
    sda_h_d    = sda_s2_q;
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    drv_d      = drv_q;
    busy_d     = busy_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    wr_valid_d = 1'b0;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    ld_d       = 1'b0;
    acked_d    = acked_q;
    if (start_c) begin
      start_d  = 1'b1;
      busy_d   = 1'b1;
      drv_d    = 1'b1;
      bitcnt_d = '0;
      acked_d  = 1'b0;
      state_d  = ADDR;
    end else if (stop_c) begin
      stop_d  = 1'b1;
      busy_d  = 1'b0;
      drv_d   = 1'b1;
      acked_d = 1'b0;
      state_d = IDLE;
    end else if (ld_q) begin
      // read byte arrives the cycle after the request
      sh_d     = rd_data_i;
      drv_d    = rd_data_i[DW-1];
      bitcnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: drv_d = 1'b1;
        ADDR: begin
          if (scl_rise) begin
            sh_d     = {sh_q[DW-2:0], sda_s2_q};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rw_d    = sda_s2_q;
              state_d = (sh_q[6:0] == I2C_DEVICE_ADDR) ? ADDR_ACK : WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (drv_q) begin
              drv_d = 1'b0;
            end else begin
              drv_d    = 1'b1;
              bitcnt_d = '0;
              if (rw_q) begin
                rd_req_d = 1'b1;
                ld_d     = 1'b1;
                state_d  = RD_DATA;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            sh_d     = {sh_q[DW-2:0], sda_s2_q};
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              wr_valid_d = 1'b1;
              wr_data_d  = {sh_q[DW-2:0], sda_s2_q};
              state_d    = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (drv_q) begin
              drv_d = 1'b0;
            end else begin
              drv_d    = 1'b1;
              bitcnt_d = '0;
              state_d  = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bitcnt_q == 3'd7) begin
              drv_d    = 1'b1;
              bitcnt_d = '0;
              acked_d  = 1'b0;
              state_d  = RD_ACK;
            end else begin
              drv_d    = sh_q[DW-2];
              sh_d     = {sh_q[DW-2:0], 1'b0};
              bitcnt_d = bitcnt_q + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s2_q) state_d = WAIT_STOP;
            else          acked_d = 1'b1;
          end else if (scl_fall && acked_q) begin
            rd_req_d = 1'b1;
            ld_d     = 1'b1;
            acked_d  = 1'b0;
            state_d  = RD_DATA;
          end
        end
        WAIT_STOP: drv_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    sda_o      = drv_q;
    busy_o     = busy_q;
    start_o    = start_q;
    stop_o     = stop_q;
    wr_valid_o = wr_valid_q;
    wr_data_o  = wr_data_q;
    rd_req_o   = rd_req_q;
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: bus-level master model driving the responder,
// with a queue scoreboard checking delivered write bytes and read fetches.
module tb_i2c_slave_responder;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_o, busy_o, start_o, stop_o;
  logic       wr_valid_o, rd_req_o;
  logic [7:0] wr_data_o;
  logic [7:0] rd_data_i = 8'h00;
  wire        sda_bus = sda_m & sda_o;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_stop = 0, n_wr = 0, n_rd = 0, n_low = 0;
  int s_start, s_stop, s_wr, s_rd, s_low;
  logic [7:0] wr_exp[$];
  logic [7:0] rd_sup[$];
  logic [7:0] mon_e;
  logic [7:0] d;
  logic       ack;

  always #5 clk = ~clk;

  i2c_slave_responder #(
    .I2C_DEVICE_ADDR(7'h22),
    .I2C_DATA_WIDTH (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .busy_o    (busy_o),
    .start_o   (start_o),
    .stop_o    (stop_o),
    .wr_valid_o(wr_valid_o),
    .wr_data_o (wr_data_o),
    .rd_req_o  (rd_req_o),
    .rd_data_i (rd_data_i)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // monitor: pops expected write bytes, supplies read bytes, counts pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (start_o) n_start++;
      if (stop_o) n_stop++;
      if (sda_o === 1'b0) n_low++;
      if (wr_valid_o) begin
        n_wr++;
        if (wr_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got 0x%0h, expected no write",
                   wr_data_o);
        end else begin
          mon_e = wr_exp.pop_front();
          chk("wr_data", {24'h0, wr_data_o}, {24'h0, mon_e});
        end
      end
      if (rd_req_o) begin
        n_rd++;
        if (rd_sup.size() > 0) rd_data_i = rd_sup.pop_front();
        else rd_data_i = 8'hFF;
      end
    end
  end

  task automatic wq(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      wq();
      sda_m = b[7-i];
      wq();
      scl_m = 1'b1;
      wq(2);
      scl_m = 1'b0;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic a);
    send_bits(b, 8);
    wq(); sda_m = 1'b1;
    wq(); scl_m = 1'b1;
    wq(); a = sda_bus;
    wq(); scl_m = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] r, input logic nack);
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wq(); sda_m = 1'b1;
      wq(); scl_m = 1'b1;
      wq(); r = {r[6:0], sda_bus};
      wq(); scl_m = 1'b0;
    end
    wq(); sda_m = nack;
    wq(); scl_m = 1'b1;
    wq(2); scl_m = 1'b0;
  endtask

  task automatic snap();
    s_start = n_start; s_stop = n_stop;
    s_wr = n_wr; s_rd = n_rd; s_low = n_low;
  endtask

  task automatic chk_counts(input string t, input int es, input int ep,
                            input int ew, input int er);
    chk({t, "_start_cnt"}, n_start - s_start, es);
    chk({t, "_stop_cnt"}, n_stop - s_stop, ep);
    chk({t, "_wr_cnt"}, n_wr - s_wr, ew);
    chk({t, "_rd_cnt"}, n_rd - s_rd, er);
    chk({t, "_wr_queue_empty"}, wr_exp.size(), 0);
  endtask

  task automatic t1();
    snap();
    bus_start();
    wq();
    chk("t1_busy_high", busy_o, 1);
    write_byte(8'h44, ack); chk("t1_addr_ack", ack, 0);
    wr_exp.push_back(8'h44);
    write_byte(8'h44, ack); chk("t1_d0_ack", ack, 0);
    wr_exp.push_back(8'h78);
    write_byte(8'h78, ack); chk("t1_d1_ack", ack, 0);
    bus_stop();
    chk("t1_busy_low", busy_o, 0);
    chk_counts("t1", 1, 1, 2, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_state",
        {25'h0, sda_o, busy_o, start_o, stop_o, wr_valid_o, rd_req_o, 1'b0},
        {25'h0, 7'b1000000});
    chk("reset_wr_data", wr_data_o, 8'h00);
    rst = 1'b0;
    wq(2);

    t1();

    snap();
    rd_sup.push_back(8'hA5);
    rd_sup.push_back(8'h3C);
    bus_start();
    write_byte(8'h45, ack); chk("t2_addr_ack", ack, 0);
    read_byte(d, 1'b0); chk("t2_rd0", d, 8'hA5);
    read_byte(d, 1'b1); chk("t2_rd1", d, 8'h3C);
    wq();
    chk("t2_sda_released", sda_o, 1);
    bus_stop();
    chk_counts("t2", 1, 1, 0, 2);

    snap();
    bus_start();
    write_byte(8'h46, ack); chk("t3_addr_nack", ack, 1);
    write_byte(8'h55, ack); chk("t3_data_nack", ack, 1);
    bus_stop();
    chk("t3_sda_never_low", n_low - s_low, 0);
    chk_counts("t3", 1, 1, 0, 0);

    snap();
    wr_exp.push_back(8'h10);
    rd_sup.push_back(8'h96);
    bus_start();
    write_byte(8'h44, ack); chk("t4_waddr_ack", ack, 0);
    write_byte(8'h10, ack); chk("t4_wdata_ack", ack, 0);
    bus_start();
    write_byte(8'h45, ack); chk("t4_raddr_ack", ack, 0);
    read_byte(d, 1'b1); chk("t4_rd", d, 8'h96);
    bus_stop();
    chk_counts("t4", 2, 1, 1, 1);

    wr_exp.push_back(8'h5A);
    bus_start();
    write_byte(8'h44, ack); chk("t5_addr_ack", ack, 0);
    send_bits(8'h5A, 8);
    wq();
    chk("t5_ack_driven", sda_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_reset_release", sda_o, 1);
    @(negedge clk);
    rst = 1'b0;
    wq();
    bus_stop();
    wq();
    chk("t5_wr_queue_empty", wr_exp.size(), 0);
    t1();

    snap();
    bus_start();
    write_byte(8'h44, ack); chk("t6_addr_ack", ack, 0);
    send_bits(8'hB0, 4);
    bus_stop();
    chk("t6_busy_low", busy_o, 0);
    chk_counts("t6", 1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
